// File: rtl/operand_fwd_stage_if.sv
// Decode/forwarding/execute bundle for the operand forwarding stage.
interface operand_fwd_stage_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
);
    // decode side
    logic             id_valid;
    logic [AW-1:0]    id_addr_s;
    logic [AW-1:0]    id_addr_t;
    logic             id_uses_s;
    logic             id_uses_t;
    logic [AW-1:0]    id_dest;
    logic             id_wr_en;
    logic             id_is_load;
    // register file read data
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    // execute handshake
    logic             ex_ready;
    // MEM result
    logic             mem_wr_en;
    logic [AW-1:0]    mem_dest;
    logic [WIDTH-1:0] mem_data;
    logic             mem_fwd_ok;
    // WB result
    logic             wb_wr_en;
    logic [AW-1:0]    wb_dest;
    logic [WIDTH-1:0] wb_data;
    // stage outputs
    logic             stall;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_op_s;
    logic [WIDTH-1:0] ex_op_t;
    logic [AW-1:0]    ex_dest;
    logic             ex_wr_en;
    logic             ex_is_load;
    logic [15:0]      stall_cnt;

    modport master (
        output id_valid, id_addr_s, id_addr_t, id_uses_s, id_uses_t,
               id_dest, id_wr_en, id_is_load, rs, rt, ex_ready,
               mem_wr_en, mem_dest, mem_data, mem_fwd_ok,
               wb_wr_en, wb_dest, wb_data,
        input  stall, ex_valid, ex_op_s, ex_op_t, ex_dest, ex_wr_en,
               ex_is_load, stall_cnt
    );

    modport slave (
        input  id_valid, id_addr_s, id_addr_t, id_uses_s, id_uses_t,
               id_dest, id_wr_en, id_is_load, rs, rt, ex_ready,
               mem_wr_en, mem_dest, mem_data, mem_fwd_ok,
               wb_wr_en, wb_dest, wb_data,
        output stall, ex_valid, ex_op_s, ex_op_t, ex_dest, ex_wr_en,
               ex_is_load, stall_cnt
    );
endinterface

// File: rtl/operand_fwd_stage.sv
// Decode-to-execute stage: operand capture, MEM/WB forwarding, hazard stall.
module operand_fwd_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
) (
    input  logic clk,
    input  logic rst,
    operand_fwd_stage_if.slave bus
);
    localparam int unsigned CNT_W = 16;

    logic             need_s;
    logic             need_t;
    logic             mem_hit_s;
    logic             mem_hit_t;
    logic             wb_hit_s;
    logic             wb_hit_t;
    logic             haz_s;
    logic             haz_t;
    logic             hazard;
    logic             stall_c;
    logic [WIDTH-1:0] op_s_c;
    logic [WIDTH-1:0] op_t_c;

    logic             ex_valid;
    logic [WIDTH-1:0] ex_op_s;
    logic [WIDTH-1:0] ex_op_t;
    logic [AW-1:0]    ex_dest;
    logic             ex_wr_en;
    logic             ex_is_load;
    logic [CNT_W-1:0] stall_cnt;

    // Source match detection and hazards that forwarding cannot cover
    always_comb begin
        need_s    = bus.id_valid & bus.id_uses_s;
        need_t    = bus.id_valid & bus.id_uses_t;
        mem_hit_s = bus.mem_wr_en & (bus.mem_dest == bus.id_addr_s);
        mem_hit_t = bus.mem_wr_en & (bus.mem_dest == bus.id_addr_t);
        wb_hit_s  = bus.wb_wr_en & (bus.wb_dest == bus.id_addr_s);
        wb_hit_t  = bus.wb_wr_en & (bus.wb_dest == bus.id_addr_t);
        haz_s     = need_s & ((ex_valid & ex_wr_en & (ex_dest == bus.id_addr_s)) |
                              (mem_hit_s & ~bus.mem_fwd_ok));
        haz_t     = need_t & ((ex_valid & ex_wr_en & (ex_dest == bus.id_addr_t)) |
                              (mem_hit_t & ~bus.mem_fwd_ok));
        hazard    = haz_s | haz_t;
        stall_c   = ~rst & bus.id_valid & (hazard | ~bus.ex_ready);
    end

    // Operand select: MEM (youngest) over WB over register file
    always_comb begin
        op_s_c = bus.rs;
        op_t_c = bus.rt;
        if (bus.id_uses_s) begin
            if (mem_hit_s & bus.mem_fwd_ok) begin
                op_s_c = bus.mem_data;
            end else if (wb_hit_s) begin
                op_s_c = bus.wb_data;
            end
        end
        if (bus.id_uses_t) begin
            if (mem_hit_t & bus.mem_fwd_ok) begin
                op_t_c = bus.mem_data;
            end else if (wb_hit_t) begin
                op_t_c = bus.wb_data;
            end
        end
    end

    // Output bundle register: hold on backpressure, bubble on hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_op_s    <= '0;
            ex_op_t    <= '0;
            ex_dest    <= '0;
            ex_wr_en   <= 1'b0;
            ex_is_load <= 1'b0;
        end else if (bus.ex_ready) begin
            if (bus.id_valid & ~hazard) begin
                ex_valid   <= 1'b1;
                ex_op_s    <= op_s_c;
                ex_op_t    <= op_t_c;
                ex_dest    <= bus.id_dest;
                ex_wr_en   <= bus.id_wr_en;
                ex_is_load <= bus.id_is_load;
            end else begin
                ex_valid <= 1'b0;
                ex_wr_en <= 1'b0;
            end
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall      = stall_c;
    assign bus.ex_valid   = ex_valid;
    assign bus.ex_op_s    = ex_op_s;
    assign bus.ex_op_t    = ex_op_t;
    assign bus.ex_dest    = ex_dest;
    assign bus.ex_wr_en   = ex_wr_en;
    assign bus.ex_is_load = ex_is_load;
    assign bus.stall_cnt  = stall_cnt;
endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed, table-driven bench for operand_fwd_stage.
module tb_operand_fwd_stage;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] exp_cnt;

    operand_fwd_stage_if #(.WIDTH(16), .AW(3)) bus ();

    operand_fwd_stage #(.WIDTH(16), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [2:0]  as;
        logic [2:0]  at;
        logic        us;
        logic        ut;
        logic [2:0]  dest;
        logic        wr;
        logic        ld;
        logic [15:0] rs;
        logic [15:0] rt;
        logic        rdy;
        logic        mwr;
        logic [2:0]  mdest;
        logic [15:0] mdata;
        logic        mok;
        logic        wwr;
        logic [2:0]  wdest;
        logic [15:0] wdata;
        logic        x_stall;
        logic        x_valid;
        logic [15:0] x_s;
        logic [15:0] x_t;
        logic [2:0]  x_dest;
        logic        x_wr;
        logic        x_ld;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid   = v.vld;
        bus.id_addr_s  = v.as;
        bus.id_addr_t  = v.at;
        bus.id_uses_s  = v.us;
        bus.id_uses_t  = v.ut;
        bus.id_dest    = v.dest;
        bus.id_wr_en   = v.wr;
        bus.id_is_load = v.ld;
        bus.rs         = v.rs;
        bus.rt         = v.rt;
        bus.ex_ready   = v.rdy;
        bus.mem_wr_en  = v.mwr;
        bus.mem_dest   = v.mdest;
        bus.mem_data   = v.mdata;
        bus.mem_fwd_ok = v.mok;
        bus.wb_wr_en   = v.wwr;
        bus.wb_dest    = v.wdest;
        bus.wb_data    = v.wdata;
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [15:0] s,
                            input logic [15:0] t, input logic [2:0] d, input logic w,
                            input logic l);
        chk({tag, ".ex_valid"},   16'(bus.ex_valid),   16'(v));
        chk({tag, ".ex_op_s"},    bus.ex_op_s,         s);
        chk({tag, ".ex_op_t"},    bus.ex_op_t,         t);
        chk({tag, ".ex_dest"},    16'(bus.ex_dest),    16'(d));
        chk({tag, ".ex_wr_en"},   16'(bus.ex_wr_en),   16'(w));
        chk({tag, ".ex_is_load"}, 16'(bus.ex_is_load), 16'(l));
        chk({tag, ".stall_cnt"},  bus.stall_cnt,       exp_cnt);
    endtask

    initial begin
        vec_t v;
        errors  = 0;
        checks  = 0;
        exp_cnt = 16'd0;

        //            vld  as    at    us    ut    dest  wr    ld    rs        rt        rdy   mwr   mdest mdata     mok   wwr   wdest wdata     stall valid x_s       x_t       x_dst x_wr  x_ld
        // no hazard
        vecs[0]  = '{1'b1,3'd3,3'd5,1'b1,1'b1,3'd6,1'b1,1'b0,16'h1234,16'h00FF,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,16'h1234,16'h00FF,3'd6,1'b1,1'b0};
        // ALU producer A -> r2, then consumer B
        vecs[1]  = '{1'b1,3'd0,3'd1,1'b1,1'b0,3'd2,1'b1,1'b0,16'h0011,16'h0022,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,16'h0011,16'h0022,3'd2,1'b1,1'b0};
        vecs[2]  = '{1'b1,3'd2,3'd3,1'b1,1'b1,3'd7,1'b1,1'b0,16'h0000,16'h0003,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,16'h0011,16'h0022,3'd2,1'b0,1'b0};
        vecs[3]  = '{1'b1,3'd2,3'd3,1'b1,1'b1,3'd7,1'b1,1'b0,16'h0000,16'h0003,1'b1,1'b1,3'd2,16'hBEEF,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,16'hBEEF,16'h0003,3'd7,1'b1,1'b0};
        // load-use with two cycles of unreturned load data
        vecs[4]  = '{1'b1,3'd0,3'd0,1'b1,1'b0,3'd4,1'b1,1'b1,16'h0100,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,16'h0100,16'h0000,3'd4,1'b1,1'b1};
        vecs[5]  = '{1'b1,3'd1,3'd4,1'b1,1'b1,3'd5,1'b1,1'b0,16'h1111,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,16'h0100,16'h0000,3'd4,1'b0,1'b1};
        vecs[6]  = '{1'b1,3'd1,3'd4,1'b1,1'b1,3'd5,1'b1,1'b0,16'h1111,16'h0000,1'b1,1'b1,3'd4,16'hDEAD,1'b0,1'b0,3'd0,16'h0000,1'b1,1'b0,16'h0100,16'h0000,3'd4,1'b0,1'b1};
        vecs[7]  = vecs[6];
        vecs[8]  = '{1'b1,3'd1,3'd4,1'b1,1'b1,3'd5,1'b1,1'b0,16'h1111,16'h0000,1'b1,1'b1,3'd4,16'hA5A5,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,16'h1111,16'hA5A5,3'd5,1'b1,1'b0};
        // MEM beats WB on same register, both sources get it
        vecs[9]  = '{1'b1,3'd1,3'd1,1'b1,1'b1,3'd3,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,3'd1,16'h0002,1'b1,1'b1,3'd1,16'h0001,1'b0,1'b1,16'h0002,16'h0002,3'd3,1'b0,1'b0};
        // WB-only bypass
        vecs[10] = '{1'b1,3'd1,3'd2,1'b1,1'b1,3'd1,1'b1,1'b0,16'h0000,16'h0777,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b1,3'd1,16'h0001,1'b0,1'b1,16'h0001,16'h0777,3'd1,1'b1,1'b0};
        // unused source ignores EX/MEM matches
        vecs[11] = '{1'b1,3'd1,3'd0,1'b0,1'b1,3'd0,1'b0,1'b0,16'h2222,16'h3333,1'b1,1'b1,3'd1,16'h9999,1'b1,1'b1,3'd0,16'h4444,1'b0,1'b1,16'h2222,16'h4444,3'd0,1'b0,1'b0};
        // backpressure for five cycles, then accept
        for (int i = 12; i < 17; i++)
            vecs[i] = '{1'b1,3'd2,3'd3,1'b1,1'b1,3'd2,1'b1,1'b0,16'h5555,16'h6666,1'b0,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b1,16'h2222,16'h4444,3'd0,1'b0,1'b0};
        vecs[17] = '{1'b1,3'd2,3'd3,1'b1,1'b1,3'd2,1'b1,1'b0,16'h5555,16'h6666,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,16'h5555,16'h6666,3'd2,1'b1,1'b0};
        // hazard under backpressure: hold first, bubble once ready
        vecs[18] = '{1'b1,3'd2,3'd0,1'b1,1'b0,3'd3,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b1,16'h5555,16'h6666,3'd2,1'b1,1'b0};
        vecs[19] = '{1'b1,3'd2,3'd0,1'b1,1'b0,3'd3,1'b1,1'b0,16'h0000,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,16'h5555,16'h6666,3'd2,1'b0,1'b0};
        vecs[20] = '{1'b1,3'd2,3'd0,1'b1,1'b0,3'd3,1'b1,1'b0,16'h0000,16'h0000,1'b1,1'b1,3'd2,16'h7777,1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,16'h7777,16'h0000,3'd3,1'b1,1'b0};

        // reset held two cycles with a valid instruction presented
        v = vecs[0];
        drive(v);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("reset.stall", 16'(bus.stall), 16'd0);
            @(posedge clk);
            @(negedge clk);
            chk_outs("reset", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i]);
            #1;
            chk({tag, ".stall"}, 16'(bus.stall), 16'(vecs[i].x_stall));
            if (vecs[i].x_stall) exp_cnt = exp_cnt + 16'd1;
            @(posedge clk);
            @(negedge clk);
            chk_outs(tag, vecs[i].x_valid, vecs[i].x_s, vecs[i].x_t,
                     vecs[i].x_dest, vecs[i].x_wr, vecs[i].x_ld);
        end

        // reset while stalled on an EX hazard (r3 in EX)
        v = vecs[0];
        v.as = 3'd3; v.us = 1'b1; v.ut = 1'b0; v.dest = 3'd1; v.rs = 16'h0ABC;
        drive(v);
        #1;
        chk("midrst.stall_pre", 16'(bus.stall), 16'd1);
        rst = 1'b1;
        #1;
        chk("midrst.stall_rst", 16'(bus.stall), 16'd0);
        @(posedge clk);
        @(negedge clk);
        exp_cnt = 16'd0;
        chk_outs("midrst", 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst.stall_post", 16'(bus.stall), 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk_outs("midrst.reissue", 1'b1, 16'h0ABC, 16'h00FF, 3'd1, 1'b1, 1'b0);

        // long backpressure: counter saturates, bundle held
        v.rdy = 1'b0;
        v.rs  = 16'hFFFF;
        drive(v);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        exp_cnt = 16'hFFFF;
        chk_outs("sat", 1'b1, 16'h0ABC, 16'h00FF, 3'd1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("sat.hold", bus.stall_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/operand_fwd_stage.md
# operand_fwd_stage

Decode-to-execute pipeline stage of the 16-bit CPU, sitting directly downstream of the 8-entry register file. It drives the register file read addresses, captures the two read operands, and replaces stale values with results still in flight in MEM or WB. It detects data hazards that forwarding cannot resolve and stalls decode. It presents a registered, valid-qualified operand bundle to execute.

## Interface
- WIDTH, 16, operand/data width
- AW, 3, register address width (8 registers, all writable, no hardwired zero)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode presents an instruction
- id_addr_s / id_addr_t  in  AW  source register numbers; also wired to register file AddrS/AddrT
- id_uses_s / id_uses_t  in  1  instruction actually reads that source
- id_dest  in  AW, id_wr_en  in  1, id_is_load  in  1  destination info carried forward
- rs / rt  in  WIDTH  register file read data (combinational, same cycle as addresses)
- ex_ready  in  1  execute accepts the output bundle this cycle
- mem_wr_en  in  1, mem_dest  in  AW, mem_data  in  WIDTH, mem_fwd_ok  in  1  MEM-stage result; mem_fwd_ok=0 while a load's data is not yet returned
- wb_wr_en  in  1, wb_dest  in  AW, wb_data  in  WIDTH  WB result (same signals that drive register file write port)
- stall  out  1  hold fetch/decode (combinational)
- ex_valid  out  1, ex_op_s / ex_op_t  out  WIDTH, ex_dest  out  AW, ex_wr_en  out  1, ex_is_load  out  1  registered bundle to execute
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
- Per source X in {s,t}, "needs X" = id_valid & id_uses_X.
- EX hazard: needs X & ex_valid & ex_wr_en & ex_dest == id_addr_X. The result is not yet computed, so the stage stalls regardless of instruction type.
- MEM hazard: needs X & mem_wr_en & mem_dest == id_addr_X & ~mem_fwd_ok. The stage stalls.
- hazard = EX hazard or MEM hazard on either source.
- Operand select per source, in priority order:
  - MEM match with mem_fwd_ok selects mem_data.
  - Otherwise a WB match (wb_wr_en & wb_dest == addr) selects wb_data. This bypasses the register file's write-on-edge latency.
  - Otherwise rs/rt.
- An unused source passes rs/rt unmodified, with no hazard check.
- stall = ~rst & id_valid & (hazard | ~ex_ready).
- Output register update on each edge:
  - rst: all outputs cleared.
  - Else if ~ex_ready: hold all outputs (backpressure).
  - Else if id_valid & ~hazard: load the selected operands, id_dest, id_wr_en, id_is_load; ex_valid=1.
  - Else: insert a bubble. ex_valid=0 and ex_wr_en=0. Other fields are don't-care but implemented as hold.
- ex_wr_en is forced 0 whenever ex_valid=0, so bubbles never create EX hazards.
- stall_cnt increments on every non-reset cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- Reset values: ex_valid=0, ex_op_s=ex_op_t=0, ex_dest=0, ex_wr_en=0, ex_is_load=0, stall_cnt=0. stall=0 while rst is high.
- Latency: an instruction accepted at edge N appears on ex_* after edge N (1 cycle).
- Decode holds its inputs stable while stall=1. Forwarding is re-evaluated every cycle, so a producer that moves MEM→WB→register file during a stall is still picked up correctly.
- ALU producer immediately ahead: 1 stall cycle; operand then forwarded from MEM.
- Load producer immediately ahead: 1 stall cycle for EX, plus one cycle per cycle with mem_fwd_ok=0.
- Simultaneous MEM and WB match on the same register: MEM wins (younger).
- Both sources naming the same register: both get the identical forwarded value.
- Hazard with ex_ready=0: hold takes precedence. No bubble is inserted until ex_ready=1.
- Reset mid-stall: next cycle outputs are at reset values and the pending decode instruction is simply re-presented. The block keeps no hidden state besides the output register and stall_cnt.

## Test plan
- Reset: assert rst 2 cycles with id_valid=1 → all outputs 0, stall=0, stall_cnt=0.
- No hazard: r3=16'h1234, r5=16'h00FF in register file, read s=3, t=5 → next cycle ex_op_s=16'h1234, ex_op_t=16'h00FF, ex_valid=1, stall never high.
- ALU back-to-back: instr A writes r2 (result 16'hBEEF), instr B reads r2 → one bubble (ex_valid=0 for one cycle), stall high one cycle, then B's ex_op_s=16'hBEEF taken from mem_data; stall_cnt=1.
- Load-use: load to r4, mem_fwd_ok=0 for 2 cycles, then data 16'hA5A5 → stall high 3 cycles total, B captured with 16'hA5A5.
- Priority/bypass: mem writes r1=16'h0002 and wb writes r1=16'h0001 in the same cycle → ex_op=16'h0002. With WB only (r1=16'h0001 being written this edge, register file still old) → ex_op=16'h0001.
- Backpressure and saturation: hold ex_ready=0 for 5 cycles with a valid bundle → ex_* unchanged, stall_cnt +5. Preload scenario of 65540 stalled cycles → stall_cnt=16'hFFFF.
